// File: rtl/axi_lite_master_adapter.sv
// AXI-Lite initiator: turns one val/rdy request into a single AXI-Lite read or
// write transaction and returns exactly one response message for it.
module axi_lite_master_adapter #(
  parameter int p_cnt_nbits = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_val,
  output logic                   req_rdy,
  input  logic                   req_type,
  input  logic [31:0]            req_addr,
  input  logic [31:0]            req_data,
  input  logic [3:0]             req_strb,
  output logic                   resp_val,
  input  logic                   resp_rdy,
  output logic                   resp_type,
  output logic [1:0]             resp_status,
  output logic [31:0]            resp_data,
  output logic                   awvalid,
  input  logic                   awready,
  output logic [31:0]            awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [3:0]             wstrb,
  output logic [31:0]            wdata,
  input  logic                   bvalid,
  output logic                   bready,
  input  logic [1:0]             bresp,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [31:0]            araddr,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [1:0]             rresp,
  input  logic [31:0]            rdata,
  output logic [p_cnt_nbits-1:0] err_count
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RESP} state_t;

  localparam logic [p_cnt_nbits-1:0] cnt_one = {{(p_cnt_nbits-1){1'b0}}, 1'b1};

  state_t                 state_reg;
  logic [p_cnt_nbits-1:0] err_next;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign err_next = (&err_count) ? err_count : err_count + cnt_one;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      req_rdy     <= 1'b0;
      resp_val    <= 1'b0;
      resp_type   <= 1'b0;
      resp_status <= 2'b00;
      resp_data   <= 32'h0;
      awvalid     <= 1'b0;
      awaddr      <= 32'h0;
      wvalid      <= 1'b0;
      wstrb       <= 4'h0;
      wdata       <= 32'h0;
      bready      <= 1'b0;
      arvalid     <= 1'b0;
      araddr      <= 32'h0;
      rready      <= 1'b0;
      err_count   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_rdy && req_val) begin
            req_rdy <= 1'b0;
            if (req_type) begin
              awvalid   <= 1'b1;
              awaddr    <= req_addr;
              wvalid    <= 1'b1;
              wdata     <= req_data;
              wstrb     <= req_strb;
              state_reg <= WR_REQ;
            end else begin
              arvalid   <= 1'b1;
              araddr    <= req_addr;
              state_reg <= RD_REQ;
            end
          end else begin
            req_rdy <= 1'b1;
          end
        end
        WR_REQ: begin
          // AW and W complete independently; a channel already done counts as ready.
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready    <= 1'b1;
            state_reg <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            bready      <= 1'b0;
            resp_val    <= 1'b1;
            resp_type   <= 1'b1;
            resp_status <= bresp;
            resp_data   <= 32'h0;
            if (bresp != 2'b00) err_count <= err_next;
            state_reg   <= RESP;
          end
        end
        RD_REQ: begin
          if (arready) begin
            arvalid   <= 1'b0;
            rready    <= 1'b1;
            state_reg <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (rvalid) begin
            rready      <= 1'b0;
            resp_val    <= 1'b1;
            resp_type   <= 1'b0;
            resp_status <= rresp;
            resp_data   <= rdata;
            if (rresp != 2'b00) err_count <= err_next;
            state_reg   <= RESP;
          end
        end
        RESP: begin
          if (resp_rdy) begin
            resp_val  <= 1'b0;
            req_rdy   <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master_adapter.sv
// Bench for axi_lite_master_adapter: a memory-backed AXI-Lite slave with
// per-channel delays, a transaction-level model, directed, table and random tests.
module tb_axi_lite_master_adapter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_val, req_type, resp_rdy;
  logic [31:0] req_addr, req_data;
  logic [3:0]  req_strb;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  logic        req_rdy, resp_val, resp_type;
  logic [1:0]  resp_status;
  logic [31:0] resp_data;
  logic        awvalid, wvalid, bready, arvalid, rready;
  logic [31:0] awaddr, wdata, araddr;
  logic [3:0]  wstrb;
  logic [15:0] err_count;

  logic        req_rdy_b, resp_val_b, resp_type_b;
  logic [1:0]  resp_status_b;
  logic [31:0] resp_data_b;
  logic        awvalid_b, wvalid_b, bready_b, arvalid_b, rready_b;
  logic [31:0] awaddr_b, wdata_b, araddr_b;
  logic [3:0]  wstrb_b;
  logic [1:0]  err_count_b;

  axi_lite_master_adapter #(.p_cnt_nbits(16)) dut (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy), .req_type(req_type),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb), .resp_val(resp_val),
    .resp_rdy(resp_rdy), .resp_type(resp_type), .resp_status(resp_status), .resp_data(resp_data),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .wvalid(wvalid), .wready(wready),
    .wstrb(wstrb), .wdata(wdata), .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .rvalid(rvalid), .rready(rready),
    .rresp(rresp), .rdata(rdata), .err_count(err_count));

  // Narrow-counter twin sees the same stimulus; only its saturation is checked.
  axi_lite_master_adapter #(.p_cnt_nbits(2)) dut_sat (
    .clk(clk), .reset(reset), .req_val(req_val), .req_rdy(req_rdy_b), .req_type(req_type),
    .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb), .resp_val(resp_val_b),
    .resp_rdy(resp_rdy), .resp_type(resp_type_b), .resp_status(resp_status_b), .resp_data(resp_data_b),
    .awvalid(awvalid_b), .awready(awready), .awaddr(awaddr_b), .wvalid(wvalid_b), .wready(wready),
    .wstrb(wstrb_b), .wdata(wdata_b), .bvalid(bvalid), .bready(bready_b), .bresp(bresp),
    .arvalid(arvalid_b), .arready(arready), .araddr(araddr_b), .rvalid(rvalid), .rready(rready_b),
    .rresp(rresp), .rdata(rdata), .err_count(err_count_b));

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int resp_cnt = 0;
  logic prev_rv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_rv <= resp_val;
    if (resp_val && !prev_rv) resp_cnt <= resp_cnt + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (got running, required finished)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // ---------------- AXI-Lite slave model ----------------
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  logic [1:0] s_bresp, s_rresp;
  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] last_awaddr, last_wdata, last_araddr;
  logic [3:0]  last_wstrb;
  int aw_hs = 0, w_hs = 0, ar_hs = 0, proto_err = 0;

  function automatic logic [31:0] slv_rd(input logic [31:0] a);
    return slave_mem.exists(a) ? slave_mem[a] : ~a;
  endfunction

  initial begin
    bit aw_logged, w_logged, ar_logged, b_fire, r_fire;
    bit aw_wait, w_wait, ar_wait, aw_done, w_done, ar_done;
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    logic [31:0] p_awaddr, p_wdata, p_araddr, v;
    logic [3:0]  p_wstrb;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        aw_logged = 0; w_logged = 0; ar_logged = 0; b_fire = 0; r_fire = 0;
        aw_wait = 0; w_wait = 0; ar_wait = 0; aw_done = 0; w_done = 0; ar_done = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        continue;
      end
      // Valid/payload stability, single handshake, and no early response acceptance.
      if (aw_wait && (!awvalid || awaddr !== p_awaddr)) proto_err++;
      if (w_wait && (!wvalid || wdata !== p_wdata || wstrb !== p_wstrb)) proto_err++;
      if (ar_wait && (!arvalid || araddr !== p_araddr)) proto_err++;
      if ((aw_done && awvalid) || (w_done && wvalid) || (ar_done && arvalid)) proto_err++;
      if (bready && !(aw_logged && w_logged)) proto_err++;
      if (rready && !ar_logged) proto_err++;

      if (b_fire) begin
        bvalid = 0; bresp = 0; aw_logged = 0; w_logged = 0; b_fire = 0; b_cnt = 0;
      end else if (aw_logged && w_logged && !bvalid) begin
        if (b_cnt >= b_dly) begin
          bvalid = 1; bresp = s_bresp;
          v = slv_rd(last_awaddr);
          for (int i = 0; i < 4; i++) if (last_wstrb[i]) v[8*i +: 8] = last_wdata[8*i +: 8];
          slave_mem[last_awaddr] = v;
        end else b_cnt++;
      end
      if (bvalid && bready) b_fire = 1;

      if (r_fire) begin
        rvalid = 0; rresp = 0; rdata = 0; ar_logged = 0; r_fire = 0; r_cnt = 0;
      end else if (ar_logged && !rvalid) begin
        if (r_cnt >= r_dly) begin
          rvalid = 1; rresp = s_rresp; rdata = slv_rd(last_araddr);
        end else r_cnt++;
      end
      if (rvalid && rready) r_fire = 1;

      aw_wait = 0; aw_done = 0;
      if (awvalid && !aw_logged) begin
        if (aw_cnt >= aw_dly) begin
          awready = 1; aw_logged = 1; last_awaddr = awaddr; aw_hs++; aw_cnt = 0; aw_done = 1;
        end else begin
          awready = 0; aw_cnt++; aw_wait = 1; p_awaddr = awaddr;
        end
      end else awready = 0;

      w_wait = 0; w_done = 0;
      if (wvalid && !w_logged) begin
        if (w_cnt >= w_dly) begin
          wready = 1; w_logged = 1; last_wdata = wdata; last_wstrb = wstrb; w_hs++; w_cnt = 0; w_done = 1;
        end else begin
          wready = 0; w_cnt++; w_wait = 1; p_wdata = wdata; p_wstrb = wstrb;
        end
      end else wready = 0;

      ar_wait = 0; ar_done = 0;
      if (arvalid && !ar_logged) begin
        if (ar_cnt >= ar_dly) begin
          arready = 1; ar_logged = 1; last_araddr = araddr; ar_hs++; ar_cnt = 0; ar_done = 1;
        end else begin
          arready = 0; ar_cnt++; ar_wait = 1; p_araddr = araddr;
        end
      end else arready = 0;
    end
  end

  // ---------------- transaction-level reference model ----------------
  logic [31:0] model_mem [logic [31:0]];
  int err_model = 0;
  int err_model_b = 0;

  task automatic model_txn(input bit t, input logic [31:0] a, d, input logic [3:0] s,
                           input logic [1:0] st, output logic [31:0] ed);
    logic [31:0] v;
    v = model_mem.exists(a) ? model_mem[a] : ~a;
    if (t) begin
      for (int i = 0; i < 4; i++) if (s[i]) v[8*i +: 8] = d[8*i +: 8];
      model_mem[a] = v;
      ed = 32'h0;
    end else ed = v;
    if (st != 2'b00) begin
      if (err_model < 65535) err_model++;
      if (err_model_b < 3) err_model_b++;
    end
  endtask

  task automatic set_slave(input int awd, wd, bd, ard, rd, input logic [1:0] st);
    aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
    s_bresp = st; s_rresp = st;
  endtask

  task automatic issue_req(input bit t, input logic [31:0] a, d, input logic [3:0] s);
    int n = 0;
    while (req_rdy !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    chk("req_rdy_before_issue", req_rdy, 1);
    req_val = 1; req_type = t; req_addr = a; req_data = d; req_strb = s;
    @(negedge clk);
    req_val = 0;
    acc_cyc = cyc - 1;
  endtask

  task automatic wait_resp(output int lat);
    int n = 0;
    while (resp_val !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    chk("resp_val_timeout", resp_val, 1);
    lat = cyc - acc_cyc;
  endtask

  task automatic do_txn(input string tag, input bit t, input logic [31:0] a, d, input logic [3:0] s,
                        input int awd, wd, bd, ard, rd, input logic [1:0] st, input int lat_req);
    logic [31:0] ed;
    int el, lat, rc0, aw0, w0, ar0;
    set_slave(awd, wd, bd, ard, rd, st);
    model_txn(t, a, d, s, st, ed);
    el = (lat_req >= 0) ? lat_req : (t ? 3 + ((awd > wd) ? awd : wd) + bd : 3 + ard + rd);
    rc0 = resp_cnt; aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs;
    issue_req(t, a, d, s);
    wait_resp(lat);
    chk({tag, "_type"}, resp_type, t);
    chk({tag, "_status"}, resp_status, st);
    chk({tag, "_data"}, resp_data, ed);
    chk({tag, "_latency"}, lat, el);
    chk({tag, "_err_count"}, err_count, err_model);
    chk({tag, "_err_count_sat"}, err_count_b, err_model_b);
    if (t) begin
      chk({tag, "_awaddr"}, last_awaddr, a);
      chk({tag, "_wdata"}, last_wdata, d);
      chk({tag, "_wstrb"}, last_wstrb, s);
      chk({tag, "_aw_count"}, aw_hs, aw0 + 1);
      chk({tag, "_w_count"}, w_hs, w0 + 1);
    end else begin
      chk({tag, "_araddr"}, last_araddr, a);
      chk({tag, "_ar_count"}, ar_hs, ar0 + 1);
    end
    $display("txn %-10s type=%0d addr=%h data=%h status=%b lat=%0d err=%0d", tag, t, a, resp_data,
             resp_status, lat, err_count);
    @(negedge clk);
    chk({tag, "_resp_count"}, resp_cnt, rc0 + 1);
  endtask

  typedef struct {
    bit          t;
    logic [31:0] a, d;
    logic [3:0]  s;
    int          awd, wd, bd, ard, rd;
    logic [1:0]  st;
    int          lat;
  } vec_t;

  initial begin
    vec_t tbl [8];
    logic [31:0] ed, hold_data;
    logic [1:0]  hold_status;
    int lat, rc0, aw0, w0;

    tbl[0] = '{1, 32'h10, 32'h11223344, 4'hF, 0, 0, 0, 0, 0, 2'b00, 3};
    tbl[1] = '{0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b00, 3};
    tbl[2] = '{1, 32'h10, 32'hAABBCCDD, 4'h5, 1, 2, 1, 0, 0, 2'b00, 6};
    tbl[3] = '{0, 32'h10, 32'h0,        4'h0, 0, 0, 0, 1, 2, 2'b00, 6};
    tbl[4] = '{0, 32'h20, 32'h0,        4'h0, 0, 0, 0, 0, 0, 2'b01, 3};
    tbl[5] = '{1, 32'h24, 32'h55555555, 4'h0, 0, 0, 3, 0, 0, 2'b10, 6};
    tbl[6] = '{0, 32'h24, 32'h0,        4'h0, 0, 0, 0, 3, 0, 2'b11, 6};
    tbl[7] = '{1, 32'h28, 32'hCAFEF00D, 4'hC, 4, 1, 0, 0, 0, 2'b00, 7};

    reset = 1; req_val = 0; req_type = 0; req_addr = 0; req_data = 0; req_strb = 0; resp_rdy = 1;
    set_slave(0, 0, 0, 0, 0, 2'b00);
    repeat (3) @(negedge clk);
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_valids", {awvalid, wvalid, arvalid, resp_val}, 0);
    chk("rst_readies", {bready, rready}, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_resp_data", resp_data, 0);
    chk("rst_err_count", err_count, 0);
    reset = 0;
    @(negedge clk);
    chk("post_rst_req_rdy", req_rdy, 1);

    // Minimum-latency write with all readies immediate.
    set_slave(0, 0, 0, 0, 0, 2'b00);
    model_txn(1, 32'h500, 32'hDEADBEEF, 4'hF, 2'b00, ed);
    issue_req(1, 32'h500, 32'hDEADBEEF, 4'hF);
    chk("w1_c1_valids", {awvalid, wvalid, arvalid}, 3'b110);
    chk("w1_c1_awaddr", awaddr, 32'h500);
    chk("w1_c1_wdata", wdata, 32'hDEADBEEF);
    chk("w1_c1_wstrb", wstrb, 4'hF);
    chk("w1_c1_req_rdy", req_rdy, 0);
    @(negedge clk);
    chk("w1_c2_bready", bready, 1);
    chk("w1_c2_valids", {awvalid, wvalid}, 0);
    @(negedge clk);
    chk("w1_c3_resp_val", resp_val, 1);
    chk("w1_c3_type", resp_type, 1);
    chk("w1_c3_status", resp_status, 0);
    chk("w1_c3_data", resp_data, ed);
    $display("txn w1         type=1 addr=00000500 status=%b", resp_status);
    @(negedge clk);
    chk("w1_c4_req_rdy", req_rdy, 1);
    chk("w1_c4_resp_val", resp_val, 0);

    // W handshakes three cycles before AW.
    set_slave(3, 0, 0, 0, 0, 2'b00);
    model_txn(1, 32'h504, 32'h0BADF00D, 4'h3, 2'b00, ed);
    rc0 = resp_cnt; aw0 = aw_hs; w0 = w_hs;
    issue_req(1, 32'h504, 32'h0BADF00D, 4'h3);
    chk("wearly_c1_valids", {awvalid, wvalid}, 2'b11);
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      chk("wearly_wvalid_dropped", wvalid, 0);
      chk("wearly_awvalid_held", awvalid, 1);
      chk("wearly_no_bready", bready, 0);
    end
    @(negedge clk);
    chk("wearly_c5_awvalid", awvalid, 0);
    chk("wearly_c5_bready", bready, 1);
    wait_resp(lat);
    chk("wearly_latency", lat, 6);
    chk("wearly_status", resp_status, 0);
    $display("txn wearly     type=1 addr=00000504 status=%b lat=%0d", resp_status, lat);
    @(negedge clk);
    chk("wearly_one_resp", resp_cnt, rc0 + 1);
    chk("wearly_one_aw", aw_hs, aw0 + 1);
    chk("wearly_one_w", w_hs, w0 + 1);

    // Read with slow AR and R.
    slave_mem[32'h500] = 32'hEFBEADDE;
    model_mem[32'h500] = 32'hEFBEADDE;
    set_slave(0, 0, 0, 2, 5, 2'b00);
    model_txn(0, 32'h500, 0, 0, 2'b00, ed);
    issue_req(0, 32'h500, 32'h0, 4'h0);
    for (int c = 1; c <= 3; c++) begin
      chk("rd_arvalid_held", arvalid, 1);
      chk("rd_araddr_stable", araddr, 32'h500);
      chk("rd_no_rready", rready, 0);
      @(negedge clk);
    end
    chk("rd_c4_arvalid", arvalid, 0);
    chk("rd_c4_rready", rready, 1);
    wait_resp(lat);
    chk("rd_latency", lat, 10);
    chk("rd_data", resp_data, 32'hEFBEADDE);
    chk("rd_data_model", resp_data, ed);
    chk("rd_status", resp_status, 0);
    $display("txn rdslow     type=0 addr=00000500 data=%h lat=%0d", resp_data, lat);
    @(negedge clk);

    // Error statuses and counter saturation.
    do_txn("err_rd", 0, 32'h30, 0, 0, 0, 0, 0, 0, 0, 2'b10, 3);
    do_txn("err_wr", 1, 32'h34, 32'h12345678, 4'hF, 0, 0, 0, 0, 0, 2'b11, 3);
    chk("err_count_two", err_count, 2);
    do_txn("err3", 0, 32'h38, 0, 0, 0, 0, 0, 1, 1, 2'b11, 5);
    do_txn("err4", 1, 32'h3C, 32'h1, 4'h1, 1, 0, 0, 0, 0, 2'b10, 4);
    do_txn("err5", 0, 32'h3C, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3);
    chk("err_count_five", err_count, 5);
    chk("err_count_sat_3", err_count_b, 3);

    // Response back-pressure with a request already waiting.
    set_slave(0, 0, 0, 0, 0, 2'b00);
    model_txn(1, 32'h600, 32'h600D600D, 4'hF, 2'b00, ed);
    resp_rdy = 0;
    issue_req(1, 32'h600, 32'h600D600D, 4'hF);
    wait_resp(lat);
    hold_status = resp_status; hold_data = resp_data;
    chk("hold_first_status", hold_status, 0);
    req_val = 1; req_type = 0; req_addr = 32'h600; req_data = 0; req_strb = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("hold_resp_val", resp_val, 1);
      chk("hold_resp_fields", {resp_type, resp_status, resp_data}, {1'b1, hold_status, hold_data});
      chk("hold_req_rdy", req_rdy, 0);
      chk("hold_no_new_axi", {awvalid, wvalid, arvalid}, 0);
    end
    resp_rdy = 1;
    @(negedge clk);
    chk("hold_handoff_resp_val", resp_val, 0);
    chk("hold_handoff_req_rdy", req_rdy, 1);
    chk("hold_not_yet_issued", arvalid, 0);
    $display("txn hold       type=1 addr=00000600 status=%b", hold_status);
    @(negedge clk);
    req_val = 0;
    acc_cyc = cyc - 1;
    chk("hold_next_accepted", {req_rdy, arvalid}, 2'b01);
    model_txn(0, 32'h600, 0, 0, 2'b00, ed);
    wait_resp(lat);
    chk("hold_next_data", resp_data, ed);
    chk("hold_next_latency", lat, 3);
    $display("txn hold_rd    type=0 addr=00000600 data=%h lat=%0d", resp_data, lat);
    @(negedge clk);

    // Table-driven vectors.
    for (int i = 0; i < 8; i++)
      do_txn($sformatf("tbl%0d", i), tbl[i].t, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].awd, tbl[i].wd,
             tbl[i].bd, tbl[i].ard, tbl[i].rd, tbl[i].st, tbl[i].lat);

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      bit          t;
      logic [31:0] a, d;
      logic [3:0]  s;
      logic [1:0]  st;
      t  = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 15)) << 2;
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      st = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_txn($sformatf("rnd%0d", i), t, a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), st, -1);
    end

    // Reset while waiting for R.
    set_slave(0, 0, 0, 0, 30, 2'b00);
    issue_req(0, 32'h700, 32'h0, 4'h0);
    @(negedge clk);
    chk("mid_rst_in_rd_resp", rready, 1);
    rc0 = resp_cnt;
    reset = 1;
    @(negedge clk);
    chk("mid_rst_arvalid", arvalid, 0);
    chk("mid_rst_rready", rready, 0);
    chk("mid_rst_resp_val", resp_val, 0);
    chk("mid_rst_err_count", err_count, 0);
    chk("mid_rst_err_count_sat", err_count_b, 0);
    @(negedge clk);
    reset = 0;
    err_model = 0;
    err_model_b = 0;
    @(negedge clk);
    chk("mid_rst_req_rdy", req_rdy, 1);
    repeat (35) @(negedge clk);
    chk("mid_rst_no_resp", resp_cnt, rc0);
    $display("txn midrst     type=0 addr=00000700 discarded");
    do_txn("post_rst", 0, 32'h700, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4);

    chk("protocol_violations", proto_err, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
